// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency sweep controller for a DDS phase accumulator. A sweep
// configuration is captured into shadow registers while idle. A start
// request then steps the frequency control word from the start value towards
// the stop value. Each word is held for dwell+1 clock cycles.
//
// Sweep modes:
//   00 single up     : one pass start -> stop, then done
//   01 sawtooth      : start -> stop, jump back to start, repeat
//   10 triangle      : start -> stop -> start, repeat
//   11 (reserved)    : behaves as single up
//
// Ports:
//   clk          in   DDS clock (125 MHz), the only clock
//   rst          in   synchronous active-high reset
//   cfg_valid    in   configuration presented
//   cfg_ready    out  configuration accepted (high only while idle)
//   cfg_f_start  in   start frequency word
//   cfg_f_stop   in   stop frequency word
//   cfg_f_step   in   frequency increment per step
//   cfg_dwell    in   hold each word for cfg_dwell+1 cycles
//   cfg_mode     in   sweep mode (see above)
//   start        in   begin a sweep from the shadow configuration
//   abort        in   stop the sweep at once, holding f_word
//   f_word       out  registered frequency control word
//   busy         out  sweep in progress
//   step_tick    out  one-cycle pulse on each f_word change during a sweep
//   done         out  one-cycle pulse when a single sweep completes
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_f_start,
    input  logic [31:0]        cfg_f_stop,
    input  logic [31:0]        cfg_f_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               start,
    input  logic               abort,
    output logic [31:0]        f_word,
    output logic               busy,
    output logic               step_tick,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    state_t             state_q,     state_d;
    logic [31:0]        f_word_q,    f_word_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               step_tick_q, step_tick_d;
    logic               done_q,      done_d;

    logic [31:0]        sh_start_q,  sh_start_d;
    logic [31:0]        sh_stop_q,   sh_stop_d;
    logic [31:0]        sh_step_q,   sh_step_d;
    logic [DWELL_W-1:0] sh_dwell_q,  sh_dwell_d;
    mode_t              sh_mode_q,   sh_mode_d;

    // Candidate next words, one step up and one step down from the current word.
    // The up sum has a carry bit, so a wrap past 2^32 compares above stop and
    // saturates to stop. The down difference has a borrow bit, so an underflow
    // clamps to start. Both apply at the turn-around points as well. There
    // f_word equals stop (or start), which gives max(stop-step, start) and
    // min(start+step, stop).
    logic [32:0] up_sum;
    logic [32:0] dn_diff;
    logic [31:0] up_next;
    logic [31:0] dn_next;
    logic        dwell_exp;
    logic        degenerate;

    always_comb begin
        up_sum     = {1'b0, f_word_q} + {1'b0, sh_step_q};
        dn_diff    = {1'b0, f_word_q} - {1'b0, sh_step_q};
        up_next    = (up_sum > {1'b0, sh_stop_q}) ? sh_stop_q : up_sum[31:0];
        dn_next    = (dn_diff[32] || (dn_diff[31:0] < sh_start_q)) ? sh_start_q
                                                                   : dn_diff[31:0];
        dwell_exp  = (dwell_cnt_q == '0);
        degenerate = (sh_step_q == '0) || (sh_start_q >= sh_stop_q);
    end

    // NOTE: every variable gets its hold/default value first, so no path through
    // the case statement leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        f_word_d    = f_word_q;
        dwell_cnt_d = dwell_cnt_q;
        step_tick_d = 1'b0;
        done_d      = 1'b0;
        sh_start_d  = sh_start_q;
        sh_stop_d   = sh_stop_q;
        sh_step_d   = sh_step_q;
        sh_dwell_d  = sh_dwell_q;
        sh_mode_d   = sh_mode_q;

        if (cfg_valid && (state_q == IDLE)) begin
            sh_start_d = cfg_f_start;
            sh_stop_d  = cfg_f_stop;
            sh_step_d  = cfg_f_step;
            sh_dwell_d = cfg_dwell;
            sh_mode_d  = mode_t'(cfg_mode);
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    f_word_d = sh_start_q;
                    if (degenerate) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN_UP;
                        dwell_cnt_d = sh_dwell_q;
                    end
                end
            end

            RUN_UP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!dwell_exp) begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end else begin
                    dwell_cnt_d = sh_dwell_q;
                    if (f_word_q != sh_stop_q) begin
                        f_word_d    = up_next;
                        step_tick_d = 1'b1;
                    end else begin
                        case (sh_mode_q)
                            MODE_SAW: begin
                                f_word_d    = sh_start_q;
                                step_tick_d = 1'b1;
                            end
                            MODE_TRI: begin
                                state_d     = RUN_DOWN;
                                f_word_d    = dn_next;
                                step_tick_d = 1'b1;
                            end
                            default: begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end

            RUN_DOWN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!dwell_exp) begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end else begin
                    dwell_cnt_d = sh_dwell_q;
                    step_tick_d = 1'b1;
                    if (f_word_q != sh_start_q) begin
                        f_word_d = dn_next;
                    end else begin
                        state_d  = RUN_UP;
                        f_word_d = up_next;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            f_word_q    <= '0;
            dwell_cnt_q <= '0;
            step_tick_q <= 1'b0;
            done_q      <= 1'b0;
            // NOTE: the shadow configuration is cleared as well. A start issued
            // straight after reset then sees step=0 and completes at once
            // instead of sweeping from an undefined value.
            sh_start_q  <= '0;
            sh_stop_q   <= '0;
            sh_step_q   <= '0;
            sh_dwell_q  <= '0;
            sh_mode_q   <= MODE_SINGLE;
        end else begin
            state_q     <= state_d;
            f_word_q    <= f_word_d;
            dwell_cnt_q <= dwell_cnt_d;
            step_tick_q <= step_tick_d;
            done_q      <= done_d;
            sh_start_q  <= sh_start_d;
            sh_stop_q   <= sh_stop_d;
            sh_step_q   <= sh_step_d;
            sh_dwell_q  <= sh_dwell_d;
            sh_mode_q   <= sh_mode_d;
        end
    end

    assign f_word    = f_word_q;
    assign busy      = (state_q != IDLE);
    assign cfg_ready = (state_q == IDLE);
    assign step_tick = step_tick_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Scoreboard bench for dds_sweep_ctrl. The stimulus pushes the expected output
// events before it drives each sweep. An event is any sample where step_tick or
// done is high, or where busy changes. Each expected event holds f_word, the
// flags, and the number of cycles since the previous event. A monitor sampling
// on the falling edge pops and compares every event the DUT presents.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    localparam int DWELL_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [31:0]        cfg_f_start;
    logic [31:0]        cfg_f_stop;
    logic [31:0]        cfg_f_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic               start;
    logic               abort;
    logic [31:0]        f_word;
    logic               busy;
    logic               step_tick;
    logic               done;

    dds_sweep_ctrl #(.DWELL_W(DWELL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_f_start (cfg_f_start),
        .cfg_f_stop  (cfg_f_stop),
        .cfg_f_step  (cfg_f_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .start       (start),
        .abort       (abort),
        .f_word      (f_word),
        .busy        (busy),
        .step_tick   (step_tick),
        .done        (done)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic        tick;
        logic        dn;
        logic        bsy;
        int          gap;   // cycles since previous event, -1 = don't care
    } ev_t;

    ev_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;
    bit  mon_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic expect_ev(input logic [31:0] f, input logic tick, input logic dn,
                             input logic bsy, input int gap);
        ev_t e;
        e.f = f; e.tick = tick; e.dn = dn; e.bsy = bsy; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: decoupled from stimulus, compares every observed event in order.
    logic prev_busy = 1'b0;
    int   gap_cnt   = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            ev_t e;
            gap_cnt++;
            if (step_tick || done || (busy != prev_busy)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: f_word=0x%0h tick=%0b done=%0b busy=%0b at %0t",
                             f_word, step_tick, done, busy, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_f_word", 64'(f_word), 64'(e.f));
                    check("ev_flags", 64'({step_tick, done, busy}), 64'({e.tick, e.dn, e.bsy}));
                    if (e.gap >= 0)
                        check("ev_gap", 64'(gap_cnt), 64'(e.gap));
                end
                gap_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic configure(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                             input logic [DWELL_W-1:0] dw, input logic [1:0] md);
        @(negedge clk);
        cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st; cfg_dwell = dw; cfg_mode = md;
        cfg_valid   = 1'b1;
        @(negedge clk);
        cfg_valid   = 1'b0;
    endtask

    // Returns at the first sample after the edge that took start (S1).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0; cfg_dwell = '0; cfg_mode = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_f_word", 64'(f_word), 64'd0);
        check("rst_flags", 64'({busy, done, step_tick}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cfg_ready_after_rst", 64'(cfg_ready), 64'd1);
        mon_en = 1'b1;

        // Abort at second cycle of 110, plus cfg_valid while busy
        configure(32'd100, 32'd130, 32'd10, 24'd2, 2'b00);
        expect_ev(32'd100, 1'b0, 1'b0, 1'b1, -1);
        expect_ev(32'd110, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd110, 1'b0, 1'b0, 1'b0, 2);
        pulse_start();                       // S1
        @(negedge clk);                      // S2
        cfg_f_start = 32'd5; cfg_f_stop = 32'd6; cfg_f_step = 32'd1;
        cfg_dwell = 24'd0; cfg_mode = 2'b01; cfg_valid = 1'b1;
        check("cfg_ready_busy", 64'(cfg_ready), 64'd0);
        @(negedge clk);                      // S3
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);           // S5
        abort = 1'b1;
        @(negedge clk);                      // S6
        abort = 1'b0;
        wait_drain();

        // Full single sweep on the unchanged shadow configuration
        expect_ev(32'd100, 1'b0, 1'b0, 1'b1, -1);
        expect_ev(32'd110, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd120, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd130, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd130, 1'b0, 1'b1, 1'b0, 3);
        pulse_start();
        wait_drain();

        // Triangle sweep, aborted after it turns back up to 110
        configure(32'd100, 32'd130, 32'd10, 24'd2, 2'b10);
        expect_ev(32'd100, 1'b0, 1'b0, 1'b1, -1);
        expect_ev(32'd110, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd120, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd130, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd120, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd110, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd100, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd110, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd110, 1'b0, 1'b0, 1'b0, 2);
        pulse_start();                       // S1
        repeat (22) @(negedge clk);          // S23
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_drain();

        // Saturation at the top of the 32-bit range
        configure(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd0, 2'b00);
        expect_ev(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, -1);
        expect_ev(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1);
        expect_ev(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
        pulse_start();
        wait_drain();

        // Degenerate: step = 0
        configure(32'd500, 32'd600, 32'd0, 24'd3, 2'b00);
        expect_ev(32'd500, 1'b0, 1'b1, 1'b0, -1);
        pulse_start();
        wait_drain();
        check("degenerate_busy", 64'(busy), 64'd0);

        // Degenerate: start >= stop
        configure(32'd700, 32'd700, 32'd5, 24'd1, 2'b01);
        expect_ev(32'd700, 1'b0, 1'b1, 1'b0, -1);
        pulse_start();
        wait_drain();

        // Abort wins over start in the same cycle: nothing happens
        configure(32'd100, 32'd130, 32'd10, 24'd2, 2'b00);
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_prio_busy", 64'(busy), 64'd0);
        check("abort_prio_f_word", 64'(f_word), 64'd700);

        // Reset mid-sweep
        configure(32'd100, 32'd130, 32'd10, 24'd2, 2'b10);
        expect_ev(32'd100, 1'b0, 1'b0, 1'b1, -1);
        expect_ev(32'd110, 1'b1, 1'b0, 1'b1, 3);
        expect_ev(32'd0,   1'b0, 1'b0, 1'b0, 2);
        pulse_start();                       // S1
        repeat (4) @(negedge clk);           // S5
        rst = 1'b1;
        @(negedge clk);                      // S6
        rst = 1'b0;
        check("rst_mid_f_word", 64'(f_word), 64'd0);
        check("rst_mid_flags", 64'({busy, done, step_tick}), 64'd0);
        check("rst_mid_cfg_ready", 64'(cfg_ready), 64'd1);
        wait_drain();

        // Shadow registers were cleared: start behaves as step = 0
        expect_ev(32'd0, 1'b0, 1'b1, 1'b0, -1);
        pulse_start();
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 24, the width of the dwell counter.
REQ-002 SHALL have port clk, input, 1 bit: the 125 MHz DDS clock; the only clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port cfg_valid, input, 1 bit: a new sweep configuration is presented.
REQ-005 SHALL have port cfg_ready, output, 1 bit: configuration can be accepted; high only in IDLE.
REQ-006 SHALL have port cfg_f_start, input, 32 bits: start frequency word.
REQ-007 SHALL have port cfg_f_stop, input, 32 bits: stop frequency word.
REQ-008 SHALL have port cfg_f_step, input, 32 bits: frequency increment per step.
REQ-009 SHALL have port cfg_dwell, input, DWELL_W bits: hold each frequency word for cfg_dwell+1 cycles.
REQ-010 SHALL have port cfg_mode, input, 2 bits: 00 single up; 01 continuous up (sawtooth); 10 continuous up/down (triangle); 11 treated as 00.
REQ-011 SHALL have port start, input, 1 bit: begin a sweep using the shadow configuration.
REQ-012 SHALL have port abort, input, 1 bit: stop the sweep immediately.
REQ-013 SHALL have port f_word, output, 32 bits: frequency control word to the DDS phase accumulator; registered.
REQ-014 SHALL have port busy, output, 1 bit: a sweep is in progress.
REQ-015 SHALL have port step_tick, output, 1 bit: one-cycle pulse on each f_word change during a sweep.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a single sweep completes.

Function
REQ-017 SHALL capture all cfg_* inputs into shadow registers on the cycle where cfg_valid && cfg_ready; while not in IDLE, cfg_valid SHALL have no effect.
REQ-018 SHALL implement the states IDLE, RUN_UP and RUN_DOWN; busy SHALL be 1 exactly when the state is not IDLE.
REQ-019 SHALL, when start=1 in IDLE at cycle T (with abort=0, shadow step≠0 and shadow start<stop), set f_word=start, load the dwell counter with the shadow dwell, and enter RUN_UP, with all of these visible from T+1.
REQ-020 SHALL, on a start in IDLE with shadow step=0 or start>=stop, set f_word=start, remain in IDLE and pulse done at T+1.
REQ-021 SHALL ignore start while busy.
REQ-022 SHALL decrement the dwell counter each busy cycle; each frequency word SHALL therefore be held for exactly dwell+1 cycles, and dwell=0 SHALL mean one update per cycle.
REQ-023 SHALL, on dwell expiry in RUN_UP with f_word≠stop, set f_word to min(f_word+step, stop), computed at 33 bits so that wrap-around saturates to stop.
REQ-024 SHALL, on dwell expiry in RUN_UP with f_word=stop, act according to mode:
- single: enter IDLE, busy=0, pulse done, f_word holds stop;
- sawtooth: f_word=start, stay in RUN_UP;
- triangle: enter RUN_DOWN, f_word=max(stop−step, start).
REQ-025 SHALL, on dwell expiry in RUN_DOWN, set f_word to max(f_word−step, start) if f_word≠start, computed with borrow detection so that underflow clamps to start.
REQ-026 SHALL, on dwell expiry in RUN_DOWN with f_word=start, enter RUN_UP with f_word=min(start+step, stop).
REQ-027 SHALL reload the dwell counter with the shadow dwell on every f_word update, and pulse step_tick in the same cycle that f_word changes.
REQ-028 SHALL, on abort=1 in any state, enter IDLE on the next cycle with f_word held, step_tick=0 and done=0.
REQ-029 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-030 SHALL keep done and step_tick mutually exclusive, each high for one cycle per event.

Reset
REQ-031 SHALL, while rst=1 on a clock edge, set state=IDLE, f_word=0, busy=0, done=0, step_tick=0, all shadow registers=0 and the dwell counter=0.
REQ-032 SHALL give rst priority over abort, start and cfg_valid; a reset during a sweep SHALL produce no done pulse.
REQ-033 SHALL drive cfg_ready=1 in the first cycle after rst is released.

Verification
REQ-034 Single sweep: cfg start=100, stop=130, step=10, dwell=2, mode=00, then start. Expected: f_word 100, 110, 120, 130, each held 3 cycles; 3 step_tick pulses; busy for 12 cycles; done pulses as busy falls.
REQ-035 Triangle sweep: same configuration with mode=10. Expected: f_word sequence 100, 110, 120, 130, 120, 110, 100, 110, ...; done never pulses.
REQ-036 Saturation: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20, dwell=0, mode=00. Expected: f_word goes 0xFFFFFFF0 then 0xFFFFFFFF with no wrap to a small value, followed by done.
REQ-037 Abort and config gating: abort at the second cycle of f_word=110. Expected: next cycle busy=0, f_word=110, no done pulse; cfg_valid asserted while busy leaves cfg_ready=0 and the shadow registers unchanged.
REQ-038 Degenerate and reset cases:
- step=0 then start: f_word=start and a done pulse at T+1 with busy staying 0;
- rst mid-sweep: f_word=0, busy=0 and no done pulse.
